// File: rtl/instr_mem_sync.sv
// Synchronous instruction memory for the IF stage: loader write port, fetch response registered one cycle after accept.
// Single-entry output register; req_ready drops while an unconsumed response is held (rsp_valid && !rsp_ready).
module instr_mem_sync #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD  = 32'hE1A00000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_pc,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_instr,
  output logic [ADDR_WIDTH-1:0] rsp_pc,
  output logic                  rsp_err,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  localparam int IW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic          accept;
  logic          rd_err;
  logic          wr_ok;
  logic          bypass;
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] wr_idx;

  assign rd_idx = req_pc[IW+1:2];
  assign wr_idx = wr_addr[IW+1:2];

  // Anything above the word-index field is out of range.
  assign rd_err = (req_pc[1:0] != 2'b00) || ((req_pc >> (IW + 2)) != '0);
  assign wr_ok  = wr_en && (wr_addr[1:0] == 2'b00) && ((wr_addr >> (IW + 2)) == '0);

  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Same-word write during a fetch returns the new data.
  assign bypass = wr_ok && (wr_idx == rd_idx);

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= FILL_WORD;
      rsp_pc    <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_pc    <= req_pc;
      rsp_err   <= rd_err;
      if (rd_err) begin
        rsp_instr <= FILL_WORD;
      end else if (bypass) begin
        rsp_instr <= wr_data;
      end else begin
        rsp_instr <= mem[rd_idx];
      end
    end else if (flush || rsp_ready) begin
      // Flush or consume without a new accept empties the slot; payload is left as-is.
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync (DEPTH=64): directed vector table, reset-in-stall sequence, randomized run vs reference model.
module tb_instr_mem_sync;

  localparam int          DEPTH = 64;
  localparam logic [31:0] NOP   = 32'hE1A00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_pc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_pc;
  logic        rsp_err;
  logic        flush;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;

  instr_mem_sync #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .DEPTH     (DEPTH),
    .FILL_WORD (NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_pc   (req_pc),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr),
    .rsp_pc   (rsp_pc),
    .rsp_err  (rsp_err),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: a word array plus the one response slot the consumer sees.
  logic [31:0] m_mem [DEPTH];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  logic        m_err;

  typedef struct {
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic        rv;
    logic [31:0] pc;
    logic        rr;
    logic        fl;
    logic        ev;
    logic [31:0] ei;
    logic [31:0] ep;
    logic        ee;
    logic        er;
  } vec_t;

  vec_t vecs[24];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                       input logic rv, input logic [31:0] pc, input logic rr, input logic fl);
    wr_en = we; wr_addr = wa; wr_data = wd;
    req_valid = rv; req_pc = pc; rsp_ready = rr; flush = fl;
  endtask

  function automatic logic model_accept();
    return req_valid && (!m_valid || rsp_ready);
  endfunction

  // Advance one clock; the model applies the write before the read (write-first).
  task automatic tick(input bit use_model);
    logic acc;
    logic bad;
    acc = model_accept();
    if (wr_en && (wr_addr % 4 == 0) && (wr_addr < 4 * DEPTH)) m_mem[wr_addr / 4] = wr_data;
    if (acc) begin
      bad     = (req_pc % 4 != 0) || (req_pc >= 4 * DEPTH);
      m_valid = 1'b1;
      m_pc    = req_pc;
      m_err   = bad;
      m_instr = bad ? NOP : m_mem[req_pc / 4];
    end else if (flush || rsp_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    if (use_model) begin
      chk("rnd_rsp_valid", {31'd0, rsp_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("rnd_rsp_instr", rsp_instr, m_instr);
        chk("rnd_rsp_pc", rsp_pc, m_pc);
        chk("rnd_rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
      end
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    logic [31:0] a;
    r = $urandom_range(0, 9);
    a = {24'd0, 6'($urandom_range(0, DEPTH - 1)), 2'b00};
    if (r == 0) a = a | 32'($urandom_range(1, 3));
    else if (r == 1) a = $urandom() | 32'h100;
    return a;
  endfunction

  initial begin
    //          we    wa       wd            rv    pc       rr    fl    ev    ei            ep       ee    er
    vecs[0]  = '{1'b1, 32'd0,   32'hE3A00014, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, NOP,          32'd0,   1'b0, 1'b1};
    vecs[1]  = '{1'b1, 32'd4,   32'hE3A01A01, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, NOP,          32'd0,   1'b0, 1'b1};
    vecs[2]  = '{1'b1, 32'd8,   32'hE3A02103, 1'b0, 32'd0,   1'b1, 1'b0, 1'b0, NOP,          32'd0,   1'b0, 1'b1};
    vecs[3]  = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd0,   1'b1, 1'b0, 1'b1, 32'hE3A00014, 32'd0,   1'b0, 1'b1};
    vecs[4]  = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd4,   1'b1, 1'b0, 1'b1, 32'hE3A01A01, 32'd4,   1'b0, 1'b1};
    vecs[5]  = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd8,   1'b1, 1'b0, 1'b1, 32'hE3A02103, 32'd8,   1'b0, 1'b1};
    vecs[6]  = '{1'b0, 32'd0,   32'd0,        1'b0, 32'd0,   1'b1, 1'b0, 1'b0, NOP,          32'd0,   1'b0, 1'b1};
    vecs[7]  = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd4,   1'b1, 1'b0, 1'b1, 32'hE3A01A01, 32'd4,   1'b0, 1'b1};
    vecs[8]  = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd8,   1'b0, 1'b0, 1'b1, 32'hE3A01A01, 32'd4,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd8,   1'b0, 1'b0, 1'b1, 32'hE3A01A01, 32'd4,   1'b0, 1'b0};
    vecs[10] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd8,   1'b0, 1'b0, 1'b1, 32'hE3A01A01, 32'd4,   1'b0, 1'b0};
    vecs[11] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd8,   1'b1, 1'b0, 1'b1, 32'hE3A02103, 32'd8,   1'b0, 1'b1};
    vecs[12] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd6,   1'b1, 1'b0, 1'b1, NOP,          32'd6,   1'b1, 1'b1};
    vecs[13] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd256, 1'b1, 1'b0, 1'b1, NOP,          32'd256, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 32'd256, 32'hDEADBEEF, 1'b1, 32'd0,   1'b1, 1'b0, 1'b1, 32'hE3A00014, 32'd0,   1'b0, 1'b1};
    vecs[15] = '{1'b1, 32'd2,   32'h12345678, 1'b1, 32'd4,   1'b1, 1'b0, 1'b1, 32'hE3A01A01, 32'd4,   1'b0, 1'b1};
    vecs[16] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd0,   1'b1, 1'b0, 1'b1, 32'hE3A00014, 32'd0,   1'b0, 1'b1};
    vecs[17] = '{1'b1, 32'd12,  32'hE0922002, 1'b1, 32'd12,  1'b1, 1'b0, 1'b1, 32'hE0922002, 32'd12,  1'b0, 1'b1};
    vecs[18] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd0,   1'b1, 1'b0, 1'b1, 32'hE3A00014, 32'd0,   1'b0, 1'b1};
    vecs[19] = '{1'b0, 32'd0,   32'd0,        1'b0, 32'd0,   1'b0, 1'b1, 1'b0, NOP,          32'd0,   1'b0, 1'b0};
    vecs[20] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd4,   1'b0, 1'b0, 1'b1, 32'hE3A01A01, 32'd4,   1'b0, 1'b1};
    vecs[21] = '{1'b0, 32'd0,   32'd0,        1'b1, 32'd8,   1'b1, 1'b1, 1'b1, 32'hE3A02103, 32'd8,   1'b0, 1'b1};
    vecs[22] = '{1'b1, 32'd8,   32'h11111111, 1'b0, 32'd0,   1'b0, 1'b0, 1'b1, 32'hE3A02103, 32'd8,   1'b0, 1'b0};
    vecs[23] = '{1'b0, 32'd0,   32'd0,        1'b0, 32'd0,   1'b1, 1'b0, 1'b0, NOP,          32'd0,   1'b0, 1'b1};

    rst = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_instr", rsp_instr, NOP);
    chk("reset_rsp_pc", rsp_pc, 32'd0);
    chk("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    #1;
    chk("reset_req_ready", {31'd0, req_ready}, 32'd1);

    // Give every word a known value so random fetches have defined expectations.
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 32'(i * 4), $urandom(), 1'b0, 32'd0, 1'b1, 1'b0);
      tick(1'b0);
    end

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].rv, vecs[i].pc, vecs[i].rr, vecs[i].fl);
      #1;
      chk($sformatf("vec%0d_req_ready", i), {31'd0, req_ready}, {31'd0, vecs[i].er});
      tick(1'b0);
      chk($sformatf("vec%0d_rsp_valid", i), {31'd0, rsp_valid}, {31'd0, vecs[i].ev});
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d_rsp_instr", i), rsp_instr, vecs[i].ei);
        chk($sformatf("vec%0d_rsp_pc", i), rsp_pc, vecs[i].ep);
        chk($sformatf("vec%0d_rsp_err", i), {31'd0, rsp_err}, {31'd0, vecs[i].ee});
      end
    end

    // Reset in the middle of a stall: valid drops without a clock, array survives.
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b0, 1'b0);
    tick(1'b0);
    drive(1'b0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
    tick(1'b0);
    chk("stall_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("async_rst_rsp_instr", rsp_instr, NOP);
    m_valid = 1'b0; m_instr = NOP; m_pc = '0; m_err = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b1, 32'd0, 1'b1, 1'b0);
    #1;
    chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
    tick(1'b0);
    chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post_rst_rsp_instr", rsp_instr, 32'hE3A00014);
    chk("post_rst_rsp_pc", rsp_pc, 32'd0);
    m_valid = rsp_valid; m_instr = 32'hE3A00014; m_pc = 32'd0; m_err = 1'b0;

    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 4) == 0, rand_addr(), $urandom(),
            $urandom_range(0, 9) < 7, rand_addr(),
            $urandom_range(0, 9) < 6, $urandom_range(0, 6) == 0);
      #1;
      chk("rnd_req_ready", {31'd0, req_ready}, {31'd0, (!m_valid || rsp_ready)});
      tick(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
Name: instr_mem_sync

Overview:
Parametrised, synchronously-read instruction memory for the ARM core's IF stage. It replaces the combinational PC-indexed ROM with a RAM-backed store that has the following features:
- a loader write port
- a one-cycle registered read
- a valid/ready handshake for stalls
- a flush that discards a fetch in flight (taken branch)
- an error flag for misaligned or out-of-range PCs

Parameters:
ADDR_WIDTH, 32, byte-address (PC) width
DATA_WIDTH, 32, instruction word width
DEPTH, 256, number of words; must be a power of two, >= 2
FILL_WORD, 32'hE1A00000, word returned on an error (MOV R0,R0 = NOP)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  fetch request present
req_ready  out  1  request accepted this cycle when req_valid=1
req_pc  in  ADDR_WIDTH  byte address of instruction
rsp_valid  out  1  instruction word valid
rsp_ready  in  1  consumer takes response (0 = IF stall)
rsp_instr  out  DATA_WIDTH  fetched instruction
rsp_pc  out  ADDR_WIDTH  PC belonging to rsp_instr
rsp_err  out  1  misaligned or out-of-range fetch
flush  in  1  discard the response held or returned next
wr_en  in  1  loader write strobe
wr_addr  in  ADDR_WIDTH  loader byte address (word-aligned)
wr_data  in  DATA_WIDTH  loader data

Behaviour:
- Indexing: word index = PC[log2(DEPTH)+1:2].
- Out of range: any set bit in PC[ADDR_WIDTH-1:log2(DEPTH)+2].
- Misaligned: PC[1:0] != 0.
- On reset: rsp_valid=0, rsp_instr=FILL_WORD, rsp_pc=0, rsp_err=0. The array is NOT cleared by reset, and contents survive reset mid-operation.
- If reset asserts while a response is pending, that response is lost. rsp_valid drops asynchronously.
- Handshake: req_ready = !rsp_valid || rsp_ready. This is combinational, a single-entry output register.
- Accept = req_valid && req_ready.
- On accept, in the next cycle:
  - rsp_valid=1
  - rsp_pc=req_pc
  - rsp_instr = mem[index], or FILL_WORD on error
  - rsp_err=1 if misaligned or out of range
  Latency is exactly 1 cycle.
- Hold: while rsp_valid && !rsp_ready, rsp_instr, rsp_pc and rsp_err are stable and no new request is accepted.
- Response consumed with no accept (rsp_valid && rsp_ready && !accept): rsp_valid goes to 0 next cycle.
- Back-to-back: with req_valid=1 and rsp_ready=1 continuously, one instruction is delivered per cycle.
- Flush:
  - With no accept the same cycle: rsp_valid=0 next cycle.
  - With an accept the same cycle: the new request is kept and only the old response is discarded.
  - Flush does not affect the array.
- Write: on a rising edge with wr_en=1:
  - if wr_addr is in range and aligned, mem[index] <= wr_data
  - otherwise the write is ignored silently
- Write and read to the same word in the same cycle is write-first: the response carries wr_data.
- Writes are independent of the handshake and allowed while stalled. The held rsp_instr is NOT updated by a later write to its address.
- Simultaneous flush, rsp_ready and accept: the result is the accepted request.

Test Plan:
- Reset then idle, DEPTH=64 -> rsp_valid=0, rsp_instr=E1A00000, req_ready=1.
- Load mem[0]=E3A00014, mem[4]=E3A01A01, mem[8]=E3A02103 via the write port; fetch PC 0,4,8 back-to-back with rsp_ready=1 -> responses E3A00014, E3A01A01, E3A02103 on consecutive cycles, rsp_pc 0,4,8, rsp_err=0.
- Fetch PC 4, then hold rsp_ready=0 for 3 cycles with req_valid=1 at PC 8 -> req_ready=0 and output frozen at E3A01A01; after rsp_ready=1, PC 8 is accepted and E3A02103 follows 1 cycle later.
- Fetch PC 6 and PC 256 (DEPTH=64) -> rsp_instr=E1A00000 with rsp_err=1 for each, and no array change.
- Write mem[12]=E0922002 while fetching PC 12 in the same cycle -> rsp_instr=E0922002.
- Fetch PC 0, then assert flush with no new request -> rsp_valid=0 next cycle.
- Flush together with an accept at PC 8 -> only the PC 8 response appears.
- Assert rst mid-stall -> rsp_valid=0 immediately; after release, fetch PC 0 returns E3A00014, showing the array is retained.
